// File: rtl/nonogram_solver.sv
// Line-constraint checker/propagator for a SIZE x SIZE nonogram board.
// Optional macro SOLVER_CONTRADICTION_EN adds a sticky contradiction output.
module nonogram_solver #(
  parameter int SIZE = 3,
  parameter int LIW  = 3,
  parameter int ONW  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SIZE-1:0]            option,
  input  logic [LIW-1:0]             line_ind,
  input  logic                       valid_op,
  input  logic                       row,
  input  logic [ONW-1:0]             option_num,
  output logic [SIZE-1:0][SIZE-1:0]  assigned,
  output logic [SIZE-1:0][SIZE-1:0]  known,
  output logic                       put_back_to_FIFO,
  output logic [ONW-1:0]             new_option_num,
`ifdef SOLVER_CONTRADICTION_EN
  output logic                       contradiction,
`endif
  output logic                       valid_out
);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t                    state_q, state_d;
  logic [SIZE-1:0]           opt_q, opt_d;
  logic [LIW-1:0]            line_q, line_d;
  logic                      row_q, row_d;
  logic [ONW-1:0]            num_q, num_d;
  logic [LIW-1:0]            prev_line_q, prev_line_d;
  logic                      new_line_q, new_line_d;
  logic [SIZE-1:0]           and_acc_q, and_acc_d;
  logic [SIZE-1:0]           or_acc_q, or_acc_d;
  logic                      any_ok_q, any_ok_d;
  logic [SIZE-1:0][SIZE-1:0] assigned_q, assigned_d;
  logic [SIZE-1:0][SIZE-1:0] known_q, known_d;
  logic                      put_q, put_d;
  logic [ONW-1:0]            nnum_q, nnum_d;
  logic                      vout_q, vout_d;
  logic                      contra_q, contra_d;

  logic [SIZE-1:0] line_known, line_val;
  logic            consistent, line_start, last;
  logic [SIZE-1:0] and_n, or_n;
  logic            any_n;

  // Gather the decided cells of the latched line into line order.
  always_comb begin
    line_known = '0;
    line_val   = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (row_q && line_q == LIW'(r)) begin
          line_known[c] = known_q[r][c];
          line_val[c]   = assigned_q[r][c];
        end
        if (!row_q && line_q == LIW'(SIZE + c)) begin
          line_known[r] = known_q[r][c];
          line_val[r]   = assigned_q[r][c];
        end
      end
    end
  end

  always_comb begin
    consistent = ~|(line_known & (line_val ^ opt_q));
    line_start = new_line_q || (line_q != prev_line_q);
    last       = (num_q <= ONW'(1));
    and_n      = line_start ? '1 : and_acc_q;
    or_n       = line_start ? '0 : or_acc_q;
    any_n      = line_start ? 1'b0 : any_ok_q;
    if (consistent) begin
      and_n = and_n & opt_q;
      or_n  = or_n | opt_q;
      any_n = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    opt_d       = opt_q;
    line_d      = line_q;
    row_d       = row_q;
    num_d       = num_q;
    prev_line_d = prev_line_q;
    new_line_d  = new_line_q;
    and_acc_d   = and_acc_q;
    or_acc_d    = or_acc_q;
    any_ok_d    = any_ok_q;
    assigned_d  = assigned_q;
    known_d     = known_q;
    put_d       = put_q;
    nnum_d      = nnum_q;
    vout_d      = 1'b0;
    contra_d    = contra_q;
    case (state_q)
      IDLE: begin
        if (valid_op) begin
          opt_d   = option;
          line_d  = line_ind;
          row_d   = row;
          num_d   = option_num;
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d     = IDLE;
        vout_d      = 1'b1;
        put_d       = consistent;
        nnum_d      = (consistent || num_q == '0) ? num_q : num_q - ONW'(1);
        and_acc_d   = and_n;
        or_acc_d    = or_n;
        any_ok_d    = any_n;
        prev_line_d = line_q;
        new_line_d  = last;
        if (last && !any_n) contra_d = 1'b1;
        // Fold into the board; decided cells are never rewritten.
        if (last && any_n) begin
          for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
              if (((row_q && line_q == LIW'(r)) || (!row_q && line_q == LIW'(SIZE + c)))
                  && !known_q[r][c]) begin
                if (row_q ? and_n[c] : and_n[r]) begin
                  known_d[r][c]    = 1'b1;
                  assigned_d[r][c] = 1'b1;
                end else if (!(row_q ? or_n[c] : or_n[r])) begin
                  known_d[r][c]    = 1'b1;
                  assigned_d[r][c] = 1'b0;
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opt_q       <= '0;
      line_q      <= '0;
      row_q       <= 1'b0;
      num_q       <= '0;
      prev_line_q <= '0;
      new_line_q  <= 1'b1;
      and_acc_q   <= '0;
      or_acc_q    <= '0;
      any_ok_q    <= 1'b0;
      assigned_q  <= '0;
      known_q     <= '0;
      put_q       <= 1'b0;
      nnum_q      <= '0;
      vout_q      <= 1'b0;
      contra_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      opt_q       <= opt_d;
      line_q      <= line_d;
      row_q       <= row_d;
      num_q       <= num_d;
      prev_line_q <= prev_line_d;
      new_line_q  <= new_line_d;
      and_acc_q   <= and_acc_d;
      or_acc_q    <= or_acc_d;
      any_ok_q    <= any_ok_d;
      assigned_q  <= assigned_d;
      known_q     <= known_d;
      put_q       <= put_d;
      nnum_q      <= nnum_d;
      vout_q      <= vout_d;
      contra_q    <= contra_d;
    end
  end

  assign assigned         = assigned_q;
  assign known            = known_q;
  assign put_back_to_FIFO = put_q;
  assign new_option_num   = nnum_q;
  assign valid_out        = vout_q;
`ifdef SOLVER_CONTRADICTION_EN
  assign contradiction    = contra_q;
`else
  logic unused_contra;
  assign unused_contra = contra_q;
`endif

endmodule

// File: tb/tb_nonogram_solver.sv
// Directed bench for nonogram_solver: vector table plus hand-written corner sequences.
module tb_nonogram_solver;
  localparam int SIZE = 3, LIW = 3, ONW = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [SIZE-1:0]           option;
  logic [LIW-1:0]            line_ind;
  logic                      valid_op;
  logic                      row;
  logic [ONW-1:0]            option_num;
  logic [SIZE-1:0][SIZE-1:0] assigned, known;
  logic                      put_back_to_FIFO;
  logic [ONW-1:0]            new_option_num;
  logic                      valid_out;
`ifdef SOLVER_CONTRADICTION_EN
  logic                      contradiction;
`endif

  nonogram_solver #(.SIZE(SIZE), .LIW(LIW), .ONW(ONW)) dut (
    .clk(clk), .rst(rst), .option(option), .line_ind(line_ind), .valid_op(valid_op),
    .row(row), .option_num(option_num), .assigned(assigned), .known(known),
    .put_back_to_FIFO(put_back_to_FIFO), .new_option_num(new_option_num),
`ifdef SOLVER_CONTRADICTION_EN
    .contradiction(contradiction),
`endif
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LIW-1:0] li;
    logic           rw;
    logic [2:0]     opt;
    logic [ONW-1:0] n;
    logic           exp_put;
    logic [ONW-1:0] exp_num;
    logic [8:0]     exp_known;     // {row2,row1,row0}, bit c within each row
    logic [8:0]     exp_asg;
  } vec_t;

  vec_t vecs[9];
  int checks = 0;
  int failures = 0;
  int pulses;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [LIW-1:0] li, input logic rw, input logic [2:0] opt,
                      input logic [ONW-1:0] n, input int hold);
    @(negedge clk);
    line_ind = li; row = rw; option = opt; option_num = n; valid_op = 1'b1;
    repeat (hold) @(negedge clk);
    valid_op = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 6; i++) begin
      if (valid_out) break;
      @(negedge clk);
    end
    check({name, "_valid_out"}, {8'b0, valid_out}, 9'd1);
  endtask

  task automatic check_vec(input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    check({nm, "_put"}, {8'b0, put_back_to_FIFO}, {8'b0, vecs[idx].exp_put});
    check({nm, "_num"}, {5'b0, new_option_num}, {5'b0, vecs[idx].exp_num});
    check({nm, "_known"}, known, vecs[idx].exp_known);
    check({nm, "_asg"}, assigned, vecs[idx].exp_asg);
  endtask

  initial begin
    vecs[0] = '{3'd0, 1'b1, 3'b100, 4'd3, 1'b1, 4'd3, 9'b000_000_000, 9'b000_000_000};
    vecs[1] = '{3'd0, 1'b1, 3'b010, 4'd2, 1'b1, 4'd2, 9'b000_000_000, 9'b000_000_000};
    vecs[2] = '{3'd0, 1'b1, 3'b001, 4'd1, 1'b1, 4'd1, 9'b000_000_000, 9'b000_000_000};
    vecs[3] = '{3'd1, 1'b1, 3'b101, 4'd1, 1'b1, 4'd1, 9'b000_111_000, 9'b000_101_000};
    vecs[4] = '{3'd3, 1'b0, 3'b000, 4'd2, 1'b0, 4'd1, 9'b000_111_000, 9'b000_101_000};
    vecs[5] = '{3'd3, 1'b0, 3'b010, 4'd1, 1'b1, 4'd1, 9'b001_111_001, 9'b000_101_000};
    vecs[6] = '{3'd2, 1'b1, 3'b010, 4'd1, 1'b1, 4'd1, 9'b011_111_001, 9'b010_101_000};
    vecs[7] = '{3'd0, 1'b1, 3'b000, 4'd0, 1'b1, 4'd0, 9'b011_111_111, 9'b010_101_000};
    vecs[8] = '{3'd5, 1'b0, 3'b000, 4'd0, 1'b0, 4'd0, 9'b011_111_111, 9'b010_101_000};

    rst = 1'b1; valid_op = 1'b0; option = '0; line_ind = '0; row = 1'b0; option_num = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_known", known, 9'd0);
    check("rst_asg", assigned, 9'd0);
    check("rst_valid_out", {8'b0, valid_out}, 9'd0);
    check("rst_put", {8'b0, put_back_to_FIFO}, 9'd0);

    for (int i = 0; i <= 5; i++) begin
      send(vecs[i].li, vecs[i].rw, vecs[i].opt, vecs[i].n, 1);
      wait_valid($sformatf("vec%0d", i));
      check_vec(i);
    end

    // valid_op held for two cycles must be consumed once.
    pulses = 0;
    fork
      send(3'd2, 1'b1, 3'b110, 4'd2, 2);
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (valid_out) pulses++;
        end
      end
    join
    check("hold_pulses", 9'(pulses), 9'd1);
    check("hold_put", {8'b0, put_back_to_FIFO}, 9'd1);
    check("hold_num", {5'b0, new_option_num}, 9'd2);
    check("hold_known", known, 9'b001_111_001);

    for (int i = 6; i <= 8; i++) begin
      send(vecs[i].li, vecs[i].rw, vecs[i].opt, vecs[i].n, 1);
      wait_valid($sformatf("vec%0d", i));
      check_vec(i);
    end
`ifdef SOLVER_CONTRADICTION_EN
    check("contradiction", {8'b0, contradiction}, 9'd1);
`endif

    // Reset while evaluating: no result pulse, board cleared.
    send(3'd1, 1'b1, 3'b101, 4'd1, 1);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (valid_out) pulses++;
      rst = 1'b0;
    end
    check("abort_pulses", 9'(pulses), 9'd0);
    check("abort_known", known, 9'd0);
    check("abort_asg", assigned, 9'd0);
    check("abort_put", {8'b0, put_back_to_FIFO}, 9'd0);
`ifdef SOLVER_CONTRADICTION_EN
    check("abort_contradiction", {8'b0, contradiction}, 9'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
